// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out collector: default word
// width and the FSM state encodings used by sipo_collector.
package sipo_pkg;

    localparam int SIPO_WIDTH_DEFAULT = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage

// File: rtl/shift_reg.sv
// Left-shifting bit collector with a bit counter; 'last' flags that the next
// enabled bit completes the word.
module shift_reg
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shreg_reg;
    logic [CW-1:0]    cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_reg <= '0;
            cnt_reg   <= '0;
        end else if (clr) begin
            shreg_reg <= '0;
            cnt_reg   <= '0;
        end else if (en) begin
            shreg_reg <= {shreg_reg[WIDTH-2:0], din};
            // Wrap rather than count past WIDTH-1 for non-power-of-two widths.
            cnt_reg   <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
        end
    end

    assign q    = shreg_reg;
    assign last = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/sipo_collector.sv
// Collects WIDTH serial bits (MSB first) into a word and holds it under a
// valid/ready handshake; flags a start refused while a word is pending.
module sipo_collector
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun
);

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] dout_reg;
    logic             dout_valid_reg;
    logic             overrun_reg;

    logic             accept_start;
    logic             shift_en;
    logic             word_done;
    logic             handshake;
    logic [WIDTH-1:0] sr_q;
    logic             sr_last;

    assign handshake    = (state_reg == ST_HOLD) && dout_valid_reg && dout_ready;
    assign accept_start = start && ((state_reg == ST_IDLE) || handshake);
    assign shift_en     = (state_reg == ST_SHIFT) && din_valid;
    assign word_done    = shift_en && sr_last;

    shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept_start),
        .en   (shift_en),
        .din  (din),
        .q    (sr_q),
        .last (sr_last)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start)     state_next = ST_SHIFT;
            ST_SHIFT: if (word_done) state_next = ST_HOLD;
            ST_HOLD:  if (handshake) state_next = start ? ST_SHIFT : ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The completed word includes the bit arriving on this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            if (word_done) begin
                dout_reg       <= {sr_q[WIDTH-2:0], din};
                dout_valid_reg <= 1'b1;
            end else if (handshake) begin
                dout_valid_reg <= 1'b0;
            end
            if ((state_reg == ST_HOLD) && start && !dout_ready) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign overrun    = overrun_reg;
    assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_sipo_collector.sv
// Directed bench for sipo_collector (WIDTH=8) with hand-computed expected words.
module tb_sipo_collector;

    logic       clk;
    logic       rst;
    logic       start;
    logic       din;
    logic       din_valid;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       busy;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    sipo_collector #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_word();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_value("start_busy", 32'(busy), 32'd1);
        check_value("start_no_valid", 32'(dout_valid), 32'd0);
    endtask

    // Sends w MSB first; optionally a gap cycle before each bit and a stray
    // start pulse in the middle of the word.
    task automatic send_bits(input logic [7:0] w, input bit gapped,
                             input bit poke_start, output int edges);
        edges = 0;
        for (int i = 7; i >= 0; i--) begin
            if (gapped) begin
                din_valid = 1'b0;
                din       = ~w[i];
                tick();
                edges++;
                check_value("gap_valid", 32'(dout_valid), 32'd0);
            end
            din       = w[i];
            din_valid = 1'b1;
            start     = poke_start && (i == 4);
            tick();
            edges++;
            start = 1'b0;
            if (i != 0) begin
                check_value("mid_valid", 32'(dout_valid), 32'd0);
                check_value("mid_busy", 32'(busy), 32'd1);
            end
        end
        din_valid = 1'b0;
        din       = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [7:0] w);
        check_value({tag, "_valid"}, 32'(dout_valid), 32'd1);
        check_value({tag, "_dout"}, 32'(dout), 32'(w));
        check_value({tag, "_busy"}, 32'(busy), 32'd1);
        $display("TXN %s dout=0x%02h valid=%0b", tag, dout, dout_valid);
    endtask

    task automatic complete_handshake(input string tag, input logic [7:0] w);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check_value({tag, "_hs_valid"}, 32'(dout_valid), 32'd0);
        check_value({tag, "_hs_idle"}, 32'(busy), 32'd0);
        check_value({tag, "_hs_retain"}, 32'(dout), 32'(w));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int edges;
        rst        = 1'b0;
        start      = 1'b0;
        din        = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;

        // Outputs defined while held in reset
        #3;
        check_value("rst_dout", 32'(dout), 32'd0);
        check_value("rst_valid", 32'(dout_valid), 32'd0);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_overrun", 32'(overrun), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Basic word 1,0,1,1,0,0,1,0 -> 0xB2, valid on the edge of the 8th bit
        begin_word();
        send_bits(8'hB2, 1'b0, 1'b0, edges);
        check_value("basic_edges", 32'(edges), 32'd8);
        check_word("basic", 8'hB2);

        // Backpressure: five stalled edges with data held stable
        for (int k = 0; k < 5; k++) begin
            din       = k[0];
            din_valid = 1'b1;
            tick();
            check_value("bp_valid", 32'(dout_valid), 32'd1);
            check_value("bp_dout", 32'(dout), 32'hB2);
        end
        din_valid = 1'b0;
        complete_handshake("bp", 8'hB2);

        // Gapped valid: 16 edges for 8 bits
        begin_word();
        send_bits(8'hB2, 1'b1, 1'b0, edges);
        check_value("gap_edges", 32'(edges), 32'd16);
        check_word("gapped", 8'hB2);

        // Back-to-back: handshake and start on one edge, stray start mid-word
        start      = 1'b1;
        dout_ready = 1'b1;
        tick();
        start      = 1'b0;
        dout_ready = 1'b0;
        check_value("b2b_busy", 32'(busy), 32'd1);
        check_value("b2b_valid", 32'(dout_valid), 32'd0);
        send_bits(8'h5A, 1'b0, 1'b1, edges);
        check_value("b2b_edges", 32'(edges + 1), 32'd9);
        check_word("b2b", 8'h5A);
        check_value("shift_start_no_flag", 32'(overrun), 32'd0);

        // Overrun: start refused in HOLD, flag sticky, din ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        check_value("ovr_flag", 32'(overrun), 32'd1);
        check_value("ovr_still_hold", 32'(busy), 32'd1);
        check_value("ovr_valid", 32'(dout_valid), 32'd1);
        din       = 1'b1;
        din_valid = 1'b1;
        tick();
        tick();
        din_valid = 1'b0;
        check_value("ovr_dout_kept", 32'(dout), 32'h5A);
        complete_handshake("ovr", 8'h5A);
        check_value("ovr_sticky", 32'(overrun), 32'd1);
        tick();
        check_value("ovr_not_started", 32'(busy), 32'd0);

        // Reset mid-frame, asserted between clock edges
        begin_word();
        send_bits(8'hFF, 1'b0, 1'b0, edges);
        complete_handshake("pre_rst", 8'hFF);
        begin_word();
        din_valid = 1'b1;
        din       = 1'b1;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        check_value("mid_rst_dout", 32'(dout), 32'd0);
        check_value("mid_rst_valid", 32'(dout_valid), 32'd0);
        check_value("mid_rst_busy", 32'(busy), 32'd0);
        check_value("mid_rst_overrun", 32'(overrun), 32'd0);
        #150;
        check_value("rst_hold_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_value("post_rst_no_valid", 32'(dout_valid), 32'd0);
        end
        din_valid = 1'b0;
        check_value("post_rst_idle", 32'(busy), 32'd0);

        // Fresh word after reset carries no stale partial bits
        begin_word();
        send_bits(8'hC3, 1'b0, 1'b0, edges);
        check_word("fresh", 8'hC3);
        complete_handshake("fresh", 8'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
